movavg_window_acc: RTL and testbench

//  - Parametrised N-tap moving-sum/moving-average filter on a signed sample stream.
//  - Generalises the fixed 4-tap, 8-bit, sum-only, combinational-output filter. Adds:

---
 rtl/movavg_pkg.sv | 16 +
 rtl/movavg_ring.sv | 39 +++
 rtl/movavg_window_acc.sv | 106 ++++++++++
 tb/tb_movavg_window_acc.sv | 139 +++++++++++++
 4 files changed

// File: rtl/movavg_pkg.sv
// Shared definitions for the moving-sum / moving-average filter.
//   MOVAVG_MODE_SUM / MOVAVG_MODE_AVG : values for the MODE parameter
//   sample_t                          : default-width signed sample
//   movavg_aw()                       : accumulator width that cannot overflow
package movavg_pkg;
  localparam int MOVAVG_MODE_SUM   = 0;
  localparam int MOVAVG_MODE_AVG   = 1;
  localparam int MOVAVG_DEF_WIDTH  = 8;

  typedef logic signed [MOVAVG_DEF_WIDTH-1:0] sample_t;

  // A sum of DEPTH samples of WIDTH bits needs $clog2(DEPTH) extra bits.
  function automatic int movavg_aw(input int width, input int depth);
    return width + $clog2(depth);
  endfunction
endpackage

// File: rtl/movavg_ring.sv
// DEPTH x WIDTH circular delay line.
// Ports:
//   system1000       clock, rising edge
//   system1000_rstn  async active-low reset
//   clr              sync clear of contents and pointer
//   wr_en / wr_data  write one sample at the pointer, then advance it
//   oldest           entry at the pointer (the one about to be overwritten)
module movavg_ring #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] oldest
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PW-1:0]               r_ptr;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_mem <= '0;
      r_ptr <= '0;
    end else if (clr) begin
      r_mem <= '0;
      r_ptr <= '0;
    end else if (wr_en) begin
      r_mem[r_ptr] <= wr_data;
      r_ptr        <= (r_ptr == PW'(DEPTH-1)) ? '0 : r_ptr + PW'(1);
    end
  end

  // Zeroed slots make the warm-up sum equal the samples seen so far.
  assign oldest = r_mem[r_ptr];
endmodule

// File: rtl/movavg_window_acc.sv
// N-tap moving sum / moving average with registered output.
// Build option: define MOVAVG_ROUND_EN for round-half-up in average mode.
// Ports:
//   system1000       clock, rising edge
//   system1000_rstn  async active-low reset
//   clr              sync clear of window, accumulator and outputs
//   in_valid/in_data signed sample stream
//   out_valid        one-cycle pulse per accepted sample
//   out_data         MODE 0: wrapped window sum; MODE 1: window average
//   out_warm         window fully populated since reset/clr
module movavg_window_acc
  import movavg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = MOVAVG_MODE_SUM
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_warm
);
  localparam int AW = movavg_aw(WIDTH, DEPTH);
  localparam int SH = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic                    w_acc_en;
  logic [WIDTH-1:0]        w_oldest;
  logic signed [AW-1:0]    w_in_ext;
  logic signed [AW-1:0]    w_old_ext;
  logic signed [AW-1:0]    w_acc_nxt;
  logic signed [WIDTH-1:0] w_out_nxt;

  logic signed [AW-1:0]    r_acc;
  logic [CW-1:0]           r_cnt;
  logic                    r_vld;
  logic signed [WIDTH-1:0] r_data;

  assign w_acc_en = in_valid & ~clr;

  movavg_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ring (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .clr             (clr),
    .wr_en           (w_acc_en),
    .wr_data         (in_data),
    .oldest          (w_oldest)
  );

  assign w_in_ext  = {{SH{in_data[WIDTH-1]}},  in_data};
  assign w_old_ext = {{SH{w_oldest[WIDTH-1]}}, w_oldest};
  assign w_acc_nxt = r_acc + w_in_ext - w_old_ext;

`ifdef MOVAVG_ROUND_EN
  // One extra bit so the bias add cannot wrap; clamp covers x.5 above max.
  localparam logic signed [AW:0] RND_BIAS = (AW+1)'(2**(SH-1));
  localparam logic signed [AW:0] SMAX     = (AW+1)'(2**(WIDTH-1)-1);
  localparam logic signed [AW:0] SMIN     = (AW+1)'(-(2**(WIDTH-1)));
  logic signed [AW:0] w_rnd;
  logic signed [AW:0] w_rnd_sh;
  assign w_rnd    = {w_acc_nxt[AW-1], w_acc_nxt} + RND_BIAS;
  assign w_rnd_sh = w_rnd >>> SH;
`endif

  always_comb begin
    w_out_nxt = w_acc_nxt[WIDTH-1:0];
    if (MODE == MOVAVG_MODE_AVG) begin
`ifdef MOVAVG_ROUND_EN
      if (w_rnd_sh > SMAX)      w_out_nxt = SMAX[WIDTH-1:0];
      else if (w_rnd_sh < SMIN) w_out_nxt = SMIN[WIDTH-1:0];
      else                      w_out_nxt = WIDTH'(w_rnd_sh);
`else
      w_out_nxt = WIDTH'(w_acc_nxt >>> SH);
`endif
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (clr) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_acc  <= w_acc_nxt;
        r_data <= w_out_nxt;
        if (r_cnt != CW'(DEPTH)) r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign out_valid = r_vld;
  assign out_data  = r_data;
  assign out_warm  = (r_cnt == CW'(DEPTH));
endmodule

// File: tb/tb_movavg_window_acc.sv
module tb_movavg_window_acc;
  logic              clk = 1'b0;
  logic              rstn;
  logic              clr;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              s_valid, s_warm, a_valid, a_warm;
  logic signed [7:0] s_data, a_data;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  movavg_window_acc #(.WIDTH(8), .DEPTH(4), .MODE(0)) u_sum (
    .system1000(clk), .system1000_rstn(rstn), .clr(clr), .in_valid(in_valid),
    .in_data(in_data), .out_valid(s_valid), .out_data(s_data), .out_warm(s_warm));

  movavg_window_acc #(.WIDTH(8), .DEPTH(4), .MODE(1)) u_avg (
    .system1000(clk), .system1000_rstn(rstn), .clr(clr), .in_valid(in_valid),
    .in_data(in_data), .out_valid(a_valid), .out_data(a_data), .out_warm(a_warm));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    in_valid = v; in_data = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    chk("rst_s_data", s_data, 8'h00);
    chk("rst_s_valid", {7'b0, s_valid}, 8'h00);
    chk("rst_s_warm", {7'b0, s_warm}, 8'h00);
    chk("rst_a_data", a_data, 8'h00);
    @(negedge clk); rstn = 1'b1;

    // warm-up 1..5 -> 1,3,6,10,14
    step(1, 8'd1, 0); chk("wu1", s_data, 8'd1);  chk("wu1_warm", {7'b0, s_warm}, 8'h00);
                      chk("wu1_valid", {7'b0, s_valid}, 8'h01);
    step(1, 8'd2, 0); chk("wu2", s_data, 8'd3);
    step(1, 8'd3, 0); chk("wu3", s_data, 8'd6);  chk("wu3_warm", {7'b0, s_warm}, 8'h00);
    step(1, 8'd4, 0); chk("wu4", s_data, 8'd10); chk("wu4_warm", {7'b0, s_warm}, 8'h01);
    step(1, 8'd5, 0); chk("wu5", s_data, 8'd14); chk("wu5_warm", {7'b0, s_warm}, 8'h01);
`ifdef MOVAVG_ROUND_EN
    chk("wu5_avg", a_data, 8'd4);
`else
    chk("wu5_avg", a_data, 8'd3);
`endif

    // clr colliding with a valid sample: sample 9 must be dropped
    step(1, 8'd9, 1);
    chk("clr_valid", {7'b0, s_valid}, 8'h00);
    chk("clr_data", s_data, 8'h00);
    chk("clr_warm", {7'b0, s_warm}, 8'h00);
    chk("clr_a_data", a_data, 8'h00);

    // wrap: 4 x 100 -> 400 mod 256 = 0x90, avg 100
    step(1, 8'd100, 0); step(1, 8'd100, 0); step(1, 8'd100, 0);
    chk("wrap3", s_data, 8'h2C);
    step(1, 8'd100, 0);
    chk("wrap4", s_data, 8'h90);
    chk("wrap_avg", a_data, 8'd100);
    chk("wrap_warm", {7'b0, s_warm}, 8'h01);

    // idle cycle: valid drops, data holds
    step(0, 8'd55, 0);
    chk("hold_valid", {7'b0, s_valid}, 8'h00);
    chk("hold_data", s_data, 8'h90);

    // negative average: 4 x -3 -> sum -12, avg -3
    step(0, 8'd0, 1);
    step(1, 8'hFD, 0); step(1, 8'hFD, 0); step(1, 8'hFD, 0); step(1, 8'hFD, 0);
    chk("neg_sum", s_data, 8'hF4);
    chk("neg_avg", a_data, 8'hFD);

    // 1,0,0,0 -> avg 0 either way
    step(0, 8'd0, 1);
    step(1, 8'd1, 0); step(1, 8'd0, 0); step(1, 8'd0, 0); step(1, 8'd0, 0);
    chk("small_avg", a_data, 8'h00);

    // 1,1,0,0 -> sum 2 -> 1 rounded, 0 floor
    step(0, 8'd0, 1);
    step(1, 8'd1, 0); step(1, 8'd1, 0); step(1, 8'd0, 0); step(1, 8'd0, 0);
    chk("rnd_sum", s_data, 8'd2);
`ifdef MOVAVG_ROUND_EN
    chk("rnd_avg", a_data, 8'd1);
`else
    chk("rnd_avg", a_data, 8'd0);
`endif

    // 4 x 127 -> avg 127, sum 508 mod 256 = 0xFC
    step(0, 8'd0, 1);
    step(1, 8'd127, 0); step(1, 8'd127, 0); step(1, 8'd127, 0); step(1, 8'd127, 0);
    chk("max_avg", a_data, 8'h7F);
    chk("max_sum", s_data, 8'hFC);
    chk("max_warm", {7'b0, a_warm}, 8'h01);

    // clr while warm and valid
    step(1, 8'd50, 1);
    chk("clr2_warm", {7'b0, a_warm}, 8'h00);
    chk("clr2_data", a_data, 8'h00);

    // gaps do not age the window: 5, gap, 6 -> 11
    step(1, 8'd5, 0);
    step(0, 8'd0, 0);
    step(1, 8'd6, 0);
    chk("gap_sum", s_data, 8'd11);
    chk("gap_valid", {7'b0, s_valid}, 8'h01);

    // async reset between edges
    #2 rstn = 1'b0;
    #1;
    chk("arst_data", s_data, 8'h00);
    chk("arst_valid", {7'b0, s_valid}, 8'h00);
    in_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    step(1, 8'd7, 0); chk("post7", s_data, 8'd7);
    step(1, 8'd7, 0); chk("post14", s_data, 8'd14);
`ifdef MOVAVG_ROUND_EN
    chk("post_avg", a_data, 8'd4);
`else
    chk("post_avg", a_data, 8'd3);
`endif
    step(0, 8'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
